rca_slice_sequencer: RTL and testbench
======================================

// Module: rca_slice_sequencer
// PURPOSE
//   Multi-cycle add controller sharing one external SLICE-bit ripple-carry adder slice.
//   Accepts WIDTH-bit operands plus carry-in and feeds the slice one SLICE-bit chunk
//   per clock, LSB first. It registers the inter-slice carry and assembles the sum.
//   Trades latency for area versus a full-width RCA; sits between an operand
//   producer and a result consumer, using valid/ready handshakes on both sides.
// PARAMETERS
//   WIDTH  16  operand/sum width in bits; must be an integer multiple of SLICE
//   SLICE  4   width of the shared adder slice; NSLICE = WIDTH/SLICE (>=1)
// PORTS
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous active-low reset
//   start_valid in   1       operand request valid
//   start_ready out  1       controller can accept operands (1 only in IDLE)
//   a_in        in   WIDTH   operand A, sampled on accept
//   b_in        in   WIDTH   operand B, sampled on accept
//   cin_in      in   1       carry-in, sampled on accept
//   slice_a     out  SLICE   A chunk to the shared slice adder
//   slice_b     out  SLICE   B chunk to the shared slice adder
//   slice_cin   out  1       carry into the shared slice adder
//   slice_sum   in   SLICE   slice adder sum (combinational from slice_a/b/cin)
//   slice_cout  in   1       slice adder carry-out
//   done_valid  out  1       result valid
//   done_ready  in   1       consumer accepts result
//   sum_out     out  WIDTH   result sum
//   cout_out    out  1       result carry-out
//   busy        out  1       1 in RUN or DONE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; idx, carry, operand and sum registers = 0.
//     Outputs: start_ready=1, done_valid=0, busy=0, sum_out=0, cout_out=0, slice_*=0.
//   FSM states: IDLE, RUN, DONE.
//   IDLE: on start_valid&start_ready, capture a_in/b_in into registers, cin_in into
//     carry, set idx=0, go RUN. start_valid while not in IDLE is ignored, never queued.
//   RUN: slice_a=a_reg[idx*SLICE+:SLICE], slice_b=b_reg[same bits], slice_cin=carry.
//     These are all driven from registers, with no input-to-output combinational path.
//     Each edge: sum_reg[idx*SLICE+:SLICE]<=slice_sum, carry<=slice_cout, idx<=idx+1.
//     The edge with idx==NSLICE-1 also goes DONE and resets idx to 0.
//   DONE: done_valid=1; sum_out=sum_reg, cout_out=carry, both held stable.
//     On done_valid&done_ready, go IDLE. No new accept occurs in that same cycle.
//   Outside RUN: slice_a, slice_b and slice_cin are 0.
//     sum_out/cout_out keep the last result until the next result is written.
//   Latency: accept at edge k; done_valid rises after edge k+NSLICE.
//     Minimum issue interval is NSLICE+2 cycles.
//   Arithmetic: {cout_out,sum_out} = a+b+cin, taken mod 2^(WIDTH+1); no overflow flag.
//   Reset mid-RUN or mid-DONE aborts the operation. No done_valid is produced for it.
//   NSLICE==1: RUN lasts a single cycle.
// TESTING
//   1. a=0xFFFF b=0x0001 cin=0 -> sum=0x0000, cout=1; done_valid exactly 4 cycles after accept.
//   2. a=0x1234 b=0x4321 cin=1 -> sum=0x5556, cout=0; slice_cin sequence 1,0,0,0.
//   3. done_ready held 0 for 5 cycles after result -> sum/cout/done_valid stable;
//      start_ready=0 and start_valid pulses ignored; result delivered once done_ready=1.
//   4. rst_n pulsed low after 2 RUN slices -> outputs return to reset values at once;
//      no done_valid; next op 0x00FF+0x0F01 -> sum=0x1000, cout=0.
//   5. start_valid held 1 through the done handshake -> start_ready=1 only in the cycle
//      after the handshake; the second op is accepted there and computes correctly.
//   6. 1000 random vectors vs a+b+cin at WIDTH=16/SLICE=4, WIDTH=8/SLICE=2, WIDTH=4/SLICE=4.

Source files
------------

// File: rtl/rca_slice_sequencer.sv
// rca_slice_sequencer: adds two WIDTH-bit operands one SLICE-bit chunk per clock
// on a shared external ripple-carry slice, LSB first, with valid/ready on both sides.
module rca_slice_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic [SLICE-1:0] slice_a,
  output logic [SLICE-1:0] slice_b,
  output logic             slice_cin,
  input  logic [SLICE-1:0] slice_sum,
  input  logic             slice_cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic [NSLICE-1:0][SLICE-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic last;

  assign last = idx_q == IW'(NSLICE - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  // cout is captured separately so the result stays stable while carry_q is reused by the next op
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    if (state_q == IDLE && start_valid) begin
      state_d = RUN;
      a_d     = a_in;
      b_d     = b_in;
      carry_d = cin_in;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      sum_d[idx_q] = slice_sum;
      carry_d      = slice_cout;
      idx_d        = last ? '0 : idx_q + IW'(1);
      if (last) begin
        state_d = DONE;
        cout_d  = slice_cout;
      end
    end else if (state_q == DONE && done_ready) begin
      state_d = IDLE;
    end
  end

  assign slice_a     = state_q == RUN ? a_q[idx_q] : '0;
  assign slice_b     = state_q == RUN ? b_q[idx_q] : '0;
  assign slice_cin   = state_q == RUN ? carry_q : 1'b0;
  assign start_ready = state_q == IDLE;
  assign done_valid  = state_q == DONE;
  assign busy        = state_q != IDLE;
  assign sum_out     = sum_q;
  assign cout_out    = cout_q;
endmodule

// File: tb/tb_rca_slice_sequencer.sv
// tb_rca_slice_sequencer: directed table, multi-cycle corner sequences and random
// vectors for 16/4, 8/2 and 4/4 configurations, each with its own slice adder.
module tb_rca_slice_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  int cmp = 0, bad = 0;

  logic sv, sr, ci, sci, sco, dv, dr, co, bz;
  logic [15:0] a, b, so;
  logic [3:0] sa, sb, ss;
  assign {sco, ss} = 5'(sa) + 5'(sb) + 5'(sci);
  rca_slice_sequencer #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(sv), .start_ready(sr), .a_in(a), .b_in(b),
    .cin_in(ci), .slice_a(sa), .slice_b(sb), .slice_cin(sci), .slice_sum(ss),
    .slice_cout(sco), .done_valid(dv), .done_ready(dr), .sum_out(so), .cout_out(co), .busy(bz));

  logic sv8, sr8, ci8, sci8, sco8, dv8, co8, bz8;
  logic [7:0] a8, b8, so8;
  logic [1:0] sa8, sb8, ss8;
  assign {sco8, ss8} = 3'(sa8) + 3'(sb8) + 3'(sci8);
  rca_slice_sequencer #(.WIDTH(8), .SLICE(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8), .a_in(a8), .b_in(b8),
    .cin_in(ci8), .slice_a(sa8), .slice_b(sb8), .slice_cin(sci8), .slice_sum(ss8),
    .slice_cout(sco8), .done_valid(dv8), .done_ready(1'b1), .sum_out(so8), .cout_out(co8),
    .busy(bz8));

  logic sv4, sr4, ci4, sci4, sco4, dv4, co4, bz4;
  logic [3:0] a4, b4, so4, sa4, sb4, ss4;
  assign {sco4, ss4} = 5'(sa4) + 5'(sb4) + 5'(sci4);
  rca_slice_sequencer #(.WIDTH(4), .SLICE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4), .a_in(a4), .b_in(b4),
    .cin_in(ci4), .slice_a(sa4), .slice_b(sb4), .slice_cin(sci4), .slice_sum(ss4),
    .slice_cout(sco4), .done_valid(dv4), .done_ready(1'b1), .sum_out(so4), .cout_out(co4),
    .busy(bz4));

  typedef struct {
    logic [15:0] a, b;
    logic cin;
    logic [15:0] sum;
    logic cout;
  } vec_t;
  vec_t tbl[9];

  logic [3:0] seq;
  int lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    a = av; b = bv; ci = cv; sv = 1'b1;
    step();
    sv = 1'b0;
  endtask

  task automatic wait_done();
    lat = 0;
    seq = '0;
    while (!dv && lat < 20) begin
      if (bz) seq = {seq[2:0], sci};
      step();
      lat++;
    end
  endtask

  task automatic handshake();
    dr = 1'b1;
    step();
    dr = 1'b0;
  endtask

  initial begin
    logic [16:0] e;
    logic [8:0] e8;
    logic [4:0] e4;
    logic seen;
    sv = 0; a = 0; b = 0; ci = 0; dr = 0;
    sv8 = 0; a8 = 0; b8 = 0; ci8 = 0; sv4 = 0; a4 = 0; b4 = 0; ci4 = 0;
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    tbl[2] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
    tbl[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    tbl[8] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    step();
    chk("rst_ctrl", {sr, dv, bz}, 3'b100);
    chk("rst_res", {co, so}, 17'h0);
    chk("rst_slice", {sa, sb, sci}, 9'h0);
    rst_n = 1'b1;
    step();
    foreach (tbl[i]) begin
      launch(tbl[i].a, tbl[i].b, tbl[i].cin);
      wait_done();
      chk($sformatf("lat%0d", i), lat, 4);
      chk($sformatf("sum%0d", i), {co, so}, {tbl[i].cout, tbl[i].sum});
      if (i == 1) chk("cin_seq", seq, 4'b1000);
      handshake();
      chk($sformatf("idle%0d", i), {sr, dv, bz}, 3'b100);
    end
    // result held under back-pressure while new requests are ignored
    launch(16'h1234, 16'h4321, 1'b1);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      sv = i[0]; a = 16'h1111; b = 16'h2222;
      step();
      chk($sformatf("hold_dv%0d", i), {dv, sr}, 2'b10);
      chk($sformatf("hold_sum%0d", i), {co, so}, 17'h05556);
    end
    sv = 1'b0;
    handshake();
    chk("hold_rel", {sr, dv, bz}, 3'b100);
    chk("hold_keep", {co, so}, 17'h05556);
    // asynchronous abort after two slices
    launch(16'hFFFF, 16'h1111, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {sr, dv, bz}, 3'b100);
    chk("abort_res", {co, so, sa, sb, sci}, 26'h0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= dv;
      step();
    end
    chk("abort_nodone", seen, 1'b0);
    launch(16'h00FF, 16'h0F01, 1'b0);
    wait_done();
    chk("abort_next", {co, so}, 17'h01000);
    handshake();
    // start_valid held across the done handshake
    a = 16'h2222; b = 16'h3333; ci = 1'b0; sv = 1'b1;
    step();
    wait_done();
    chk("b2b_first", {co, so}, 17'h05555);
    chk("b2b_busy_sr", sr, 1'b0);
    a = 16'hF000; b = 16'h1000; ci = 1'b1; dr = 1'b1;
    step();
    chk("b2b_gap", {sr, dv}, 2'b10);
    step();
    chk("b2b_acc", {sr, bz}, 2'b01);
    sv = 1'b0; dr = 1'b0;
    wait_done();
    chk("b2b_lat", lat, 4);
    chk("b2b_second", {co, so}, 17'h10001);
    handshake();
    for (int i = 0; i < 400; i++) begin
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
      e = 17'(a) + 17'(b) + 17'(ci);
      launch(a, b, ci);
      wait_done();
      chk($sformatf("r16_%0d", i), {lat[7:0], co, so}, {8'd4, e});
      handshake();
    end
    for (int i = 0; i < 300; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sv8 = 1'b1;
      e8 = 9'(a8) + 9'(b8) + 9'(ci8);
      step();
      sv8 = 1'b0;
      lat = 0;
      while (!dv8 && lat < 20) begin step(); lat++; end
      chk($sformatf("r8_%0d", i), {lat[7:0], co8, so8}, {8'd4, e8});
      step();
    end
    for (int i = 0; i < 300; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom); sv4 = 1'b1;
      e4 = 5'(a4) + 5'(b4) + 5'(ci4);
      step();
      sv4 = 1'b0;
      lat = 0;
      while (!dv4 && lat < 20) begin step(); lat++; end
      chk($sformatf("r4_%0d", i), {lat[7:0], co4, so4}, {8'd1, e4});
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
